// File: rtl/uart_rx.sv
// uart_rx: oversampled async receiver, 8N1 by default, even parity with UART_RX_PARITY_EN; RX_VALID one cycle after stop sample.
// Single holding register: a byte completing while RX_VALID is unconsumed overwrites RX_DATA and latches OVERRUN.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 CLK_IN,
  input  logic                 RX_RST_N,
  input  logic                 BAUD_TICK,
  input  logic                 RX_IN,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 PARITY_ERR
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic [1:0]           rst_sync_q, rst_sync_d;
  logic [1:0]           sync_q, sync_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_d;
  logic                 done;
  logic                 line;
  logic                 tick;

  assign line = sync_q[1];
  // FSM is held off until the deasserted reset has crossed both sync flops.
  assign tick = BAUD_TICK & rst_sync_q[1];

  always_comb begin
    rst_sync_d   = {rst_sync_q[0], 1'b1};
    sync_d       = {sync_q[0], RX_IN};
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    done         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!line) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = line ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shreg_d    = {line, shreg_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d   = '0;
            parity_err_d = line ^ (^shreg_q);
            state_d      = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            if (line) begin
              done    = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (line) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // A transfer in the same cycle as a new byte frees the slot, so no overrun.
    data_d    = done ? shreg_q : data_q;
    valid_d   = done | (valid_q & ~RX_READY);
    overrun_d = (overrun_q & ~(valid_q & RX_READY)) | (done & valid_q & ~RX_READY);
  end

  always_ff @(posedge CLK_IN or negedge RX_RST_N) begin
    if (!RX_RST_N) begin
      rst_sync_q  <= 2'b00;
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rst_sync_q  <= rst_sync_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  always_ff @(posedge CLK_IN or negedge RX_RST_N) begin
    if (!RX_RST_N) parity_err_q <= 1'b0;
    else           parity_err_q <= parity_err_d;
  end
  assign PARITY_ERR = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_d;
  assign PARITY_ERR    = 1'b0;
`endif

  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 100 MHz clock, BAUD_TICK every 4 clocks, OVERSAMPLE 16 (64 clocks per bit).
module tb_uart_rx;
  localparam int BIT_CLKS = 64;

  logic       CLK_IN = 1'b0;
  logic       RX_RST_N = 1'b0;
  logic       BAUD_TICK = 1'b0;
  logic       RX_IN = 1'b1;
  logic       RX_READY = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       PARITY_ERR;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cyc = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int got_rd = 0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .CLK_IN(CLK_IN), .RX_RST_N(RX_RST_N), .BAUD_TICK(BAUD_TICK), .RX_IN(RX_IN),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .PARITY_ERR(PARITY_ERR)
  );

  always #5 CLK_IN = ~CLK_IN;

  initial begin
    int tcnt = 0;
    forever begin
      @(posedge CLK_IN);
      #2;
      tcnt = (tcnt == 3) ? 0 : tcnt + 1;
      BAUD_TICK = (tcnt == 3);
    end
  end

  // Inputs change 2 ns after posedge, so a transfer at the next posedge is visible here.
  always @(negedge CLK_IN) begin
    if (RX_VALID) valid_cyc++;
    if (FRAME_ERR) fe_cnt++;
    if (PARITY_ERR) pe_cnt++;
    if (RX_VALID && RX_READY) got_q.push_back(RX_DATA);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK_IN);
    #2;
  endtask

  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (BIT_CLKS) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

  task automatic test_reset();
    RX_RST_N = 1'b0;
    RX_IN = 1'b1;
    RX_READY = 1'b1;
    repeat (5) step();
    n_checks++; if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", RX_DATA); end
    n_checks++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", RX_VALID); end
    n_checks++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", FRAME_ERR); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
    n_checks++; if (PARITY_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", PARITY_ERR); end
    RX_RST_N = 1'b1;
    repeat (BIT_CLKS) step();
  endtask

  task automatic test_basic();
    int vb = valid_cyc;
    int fb = fe_cnt;
    int pb = pe_cnt;
    logic [7:0] e;
    RX_READY = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (BIT_CLKS) step();
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() <= got_rd) begin n_fail++; $display("FAIL basic_byte: no byte, want %h", e); end
    else begin
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL basic_byte: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    n_checks++; if (valid_cyc - vb != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cyc - vb); end
    n_checks++; if (fe_cnt != fb) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_cnt - fb); end
    n_checks++; if (pe_cnt != pb) begin n_fail++; $display("FAIL basic_parity_err: got %0d pulses want 0", pe_cnt - pb); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b want 0", OVERRUN); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [4] = '{8'h00, 8'hFF, 8'h6B, 8'h80};
    logic [7:0] e;
    RX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1);
    end
    repeat (BIT_CLKS) step();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() <= got_rd) begin n_fail++; $display("FAIL b2b_byte%0d: no byte, want %h", i, e); end
      else begin
        if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[got_rd], e); end
        got_rd++;
      end
    end
  endtask

  task automatic test_glitch();
    int vb = valid_cyc;
    int fb = fe_cnt;
    logic [7:0] e;
    RX_IN = 1'b0;
    repeat (24) step();
    RX_IN = 1'b1;
    repeat (3 * BIT_CLKS) step();
    n_checks++; if (valid_cyc != vb) begin n_fail++; $display("FAIL glitch_valid: got %0d valid cycles want 0", valid_cyc - vb); end
    n_checks++; if (fe_cnt != fb) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fb); end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (BIT_CLKS) step();
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() <= got_rd) begin n_fail++; $display("FAIL glitch_after_byte: no byte, want %h", e); end
    else begin
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL glitch_after_byte: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
  endtask

  task automatic test_frame_err();
    int vb = valid_cyc;
    int fb = fe_cnt;
    logic [7:0] e;
    send_frame(8'h3C, 1'b0);
    repeat (3 * BIT_CLKS) step();
    n_checks++; if (fe_cnt - fb != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses want 1", fe_cnt - fb); end
    n_checks++; if (valid_cyc != vb) begin n_fail++; $display("FAIL ferr_valid: got %0d valid cycles want 0", valid_cyc - vb); end
    n_checks++; if (got_q.size() != got_rd) begin n_fail++; $display("FAIL ferr_no_byte: got %0d bytes want 0", got_q.size() - got_rd); end
    RX_IN = 1'b1;
    repeat (BIT_CLKS) step();
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    repeat (BIT_CLKS) step();
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() <= got_rd) begin n_fail++; $display("FAIL ferr_recover: no byte, want %h", e); end
    else begin
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL ferr_recover: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    RX_READY = 1'b0;
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (BIT_CLKS / 2) step();
    @(negedge CLK_IN);
    n_checks++; if (RX_DATA !== 8'h22) begin n_fail++; $display("FAIL ovr_data: got %h want 22", RX_DATA); end
    n_checks++; if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", RX_VALID); end
    n_checks++; if (OVERRUN !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", OVERRUN); end
    step();
    RX_READY = 1'b1;
    step();
    RX_READY = 1'b0;
    @(negedge CLK_IN);
    n_checks++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clr: got %b want 0", RX_VALID); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL ovr_flag_clr: got %b want 0", OVERRUN); end
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() <= got_rd) begin n_fail++; $display("FAIL ovr_byte: no transfer, want %h", e); end
    else begin
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL ovr_byte: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    RX_READY = 1'b0;
    send_frame(8'h81, 1'b1);
    repeat (8) step();
    n_checks++; if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", RX_VALID); end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RX_IN = 1'b1;
    repeat (BIT_CLKS / 2) step();
    RX_RST_N = 1'b0;
    #1;
    n_checks++; if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", RX_DATA); end
    n_checks++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", RX_VALID); end
    n_checks++; if (FRAME_ERR !== 1'b0 || OVERRUN !== 1'b0 || PARITY_ERR !== 1'b0) begin
      n_fail++; $display("FAIL rmid_flags: got fe=%b ovr=%b pe=%b want 0 0 0", FRAME_ERR, OVERRUN, PARITY_ERR);
    end
    repeat (10) step();
    RX_RST_N = 1'b1;
    repeat (BIT_CLKS) step();
    RX_READY = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (BIT_CLKS) step();
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() <= got_rd) begin n_fail++; $display("FAIL rmid_next: no byte, want %h", e); end
    else begin
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL rmid_next: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    n_checks++; if (got_q.size() != got_rd) begin n_fail++; $display("FAIL rmid_extra: %0d unexpected bytes", got_q.size() - got_rd); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pb = pe_cnt;
    logic [7:0] d = 8'h07;
    logic [7:0] e;
    RX_READY = 1'b1;
    exp_q.push_back(d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (BIT_CLKS) step();
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() <= got_rd) begin n_fail++; $display("FAIL par_byte: no byte, want %h", e); end
    else begin
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL par_byte: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    n_checks++; if (RX_DATA !== 8'h07) begin n_fail++; $display("FAIL par_data: got %h want 07", RX_DATA); end
    n_checks++; if (pe_cnt - pb != 1) begin n_fail++; $display("FAIL par_pulse: got %0d pulses want 1", pe_cnt - pb); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning BAUD_TICK pulses per bit period (even, 4..256).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-003 SHALL have port CLK_IN input 1, the system clock (100 MHz); all logic on posedge.
REQ-004 SHALL have port RX_RST_N input 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port BAUD_TICK input 1, a single-cycle enable at OVERSAMPLE x baud from the baud divider.
REQ-006 SHALL have port RX_IN input 1, the asynchronous serial line, idle high.
REQ-007 SHALL have port RX_DATA output DATA_BITS, the received byte, LSB = first data bit.
REQ-008 SHALL have port RX_VALID output 1, high while RX_DATA holds an unconsumed byte.
REQ-009 SHALL have port RX_READY input 1, consumer accept; transfer when RX_VALID and RX_READY are both high.
REQ-010 SHALL have port FRAME_ERR output 1, a one-cycle pulse on a stop bit sampled low.
REQ-011 SHALL have port OVERRUN output 1, sticky, set when a byte completes while RX_VALID is high; cleared by a transfer.
REQ-012 SHALL have port PARITY_ERR output 1, a one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-013 SHALL synchronise RX_IN through two flops before use; all "line" references mean the synchronised value.
REQ-014 SHALL use states IDLE, START, DATA, PARITY, STOP, BREAK; tick counter and bit counter advance only on BAUD_TICK.
REQ-015 IDLE: a line low seen on a BAUD_TICK -> START, tick counter cleared.
REQ-016 START: after OVERSAMPLE/2 ticks resample; line high -> IDLE (glitch rejected, no output); line low -> DATA.
REQ-017 DATA: sample every OVERSAMPLE ticks, shift LSB first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-018 STOP: sample after OVERSAMPLE ticks; high -> load RX_DATA, assert RX_VALID next cycle, -> IDLE; low -> pulse FRAME_ERR, discard byte, -> BREAK.
REQ-019 BREAK: remain until line is high on a BAUD_TICK, then -> IDLE.
REQ-020 RX_VALID SHALL stay high and RX_DATA stable until a transfer; a transfer clears RX_VALID the next cycle.
REQ-021 A new byte completing while RX_VALID is high SHALL overwrite RX_DATA, keep RX_VALID high and set OVERRUN.
REQ-022 When a new byte completes in the same cycle as a transfer, the new byte SHALL load, RX_VALID SHALL stay high and OVERRUN SHALL NOT set.
REQ-023 Latency SHALL be at most 2 CLK_IN cycles from the stop-bit sample tick to RX_VALID high.
REQ-024 Counters SHALL be width ceil(log2(OVERSAMPLE)) and DATA_BITS index; no wrap beyond terminal count.

Reset
REQ-025 RX_RST_N low SHALL immediately force state IDLE, counters 0, synchronisers 1, RX_DATA 0, RX_VALID 0, FRAME_ERR 0, OVERRUN 0, PARITY_ERR 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release a fresh start edge is required.
REQ-027 Reset release SHALL be synchronised internally (two-flop deassert) so no state change occurs in the release cycle.

Configuration
REQ-028 With UART_RX_PARITY_EN defined, PARITY state SHALL sample one even-parity bit after data; mismatch pulses PARITY_ERR, the byte is still delivered.
REQ-029 Without UART_RX_PARITY_EN, PARITY state SHALL be absent, the frame SHALL be 8N1 and PARITY_ERR SHALL be tied 0.

Verification
REQ-030 OVERSAMPLE=16, tick every 4 clocks, send 0xA5 8N1, RX_READY=1 -> RX_DATA=0xA5, RX_VALID high exactly 1 cycle, no error pulses.
REQ-031 Low glitch of 6 ticks on idle line -> returns to IDLE, RX_VALID stays 0, no FRAME_ERR.
REQ-032 Send 0x3C with stop bit low -> FRAME_ERR one pulse, RX_VALID 0, no new byte until line high for one tick.
REQ-033 RX_READY=0, send 0x11 then 0x22 -> RX_DATA=0x22, OVERRUN=1; assert RX_READY one cycle -> RX_VALID 0, OVERRUN 0.
REQ-034 Assert RX_RST_N low during data bit 4 of 0xFF -> all outputs 0 immediately; next frame 0x5A received correctly.
REQ-035 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> RX_DATA=0x07, RX_VALID 1, PARITY_ERR one pulse.
